// File: rtl/caf_peak_search.sv
// Peak search over CAF dot-product samples: finds the largest i^2+q^2 in each
// frame and hands the winning index and magnitude downstream.
module caf_peak_search #(
    parameter int i_bits     = 24,
    parameter int q_bits     = 24,
    parameter int frame_len  = 16,
    parameter int index_bits = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         m_axis_product_tvalid,
    input  logic signed [i_bits-1:0]     i,
    input  logic signed [q_bits-1:0]     q,
    output logic                         s_axis_product_tready,
    output logic                         s_axis_peak_tvalid,
    input  logic                         m_axis_peak_tready,
    output logic [index_bits-1:0]        peak_index,
    output logic [i_bits+q_bits-1:0]     peak_mag
);

    localparam int MW = i_bits + q_bits;
    localparam logic [index_bits-1:0] LastIdx = index_bits'(frame_len - 1);

    typedef enum logic [1:0] {IDLE, SEARCH, DRAIN, HOLD} state_t;

    state_t                 state_q, state_d;
    logic [index_bits-1:0]  cnt_q, cnt_d;
    logic [1:0]             drain_q, drain_d;
    logic                   tready_q, tready_d;
    logic                   tvalid_q, tvalid_d;
    logic [index_bits-1:0]  peakIdx_q, peakIdx_d;
    logic [MW-1:0]          peakMag_q, peakMag_d;

    logic                   v1_q, v2_q;
    logic [MW-1:0]          sqI_q, sqI_d, sqQ_q, sqQ_d;
    logic [MW-1:0]          mag2_q, mag2_d;
    logic [index_bits-1:0]  idx1_q, idx2_q;
    logic [MW-1:0]          bestMag_q, bestMag_d;
    logic [index_bits-1:0]  bestIdx_q, bestIdx_d;

    logic                   accept;
    logic                   lastAccept;
    logic                   drainDone;
    logic                   handshake;
    logic signed [MW-1:0]   iExt, qExt;

    assign accept     = m_axis_product_tvalid & tready_q;
    assign lastAccept = accept && (cnt_q == LastIdx);
    assign drainDone  = (state_q == DRAIN) && (drain_q == 2'd2);
    assign handshake  = (state_q == HOLD) && m_axis_peak_tready;

    // Widen before squaring so the full-scale negative input cannot wrap.
    assign iExt = MW'(i);
    assign qExt = MW'(q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = SEARCH;
            SEARCH:  if (lastAccept) state_d = DRAIN;
            DRAIN:   if (drainDone) state_d = HOLD;
            HOLD:    if (m_axis_peak_tready) state_d = SEARCH;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tready_d  = (state_d == SEARCH);
        tvalid_d  = tvalid_q;
        peakIdx_d = peakIdx_q;
        peakMag_d = peakMag_q;
        cnt_d     = cnt_q;
        drain_d   = (state_q == DRAIN) ? drain_q + 2'd1 : 2'd0;
        if (accept) begin
            cnt_d = lastAccept ? '0 : cnt_q + 1'b1;
        end
        if (drainDone) begin
            tvalid_d  = 1'b1;
            peakIdx_d = bestIdx_q;
            peakMag_d = bestMag_q;
        end
        if (handshake) begin
            tvalid_d = 1'b0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            drain_q   <= '0;
            tready_q  <= 1'b0;
            tvalid_q  <= 1'b0;
            peakIdx_q <= '0;
            peakMag_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            drain_q   <= drain_d;
            tready_q  <= tready_d;
            tvalid_q  <= tvalid_d;
            peakIdx_q <= peakIdx_d;
            peakMag_q <= peakMag_d;
        end
    end

    // Index 0 of a frame seeds the running best; strict > keeps the earliest tie.
    always_comb begin
        sqI_d     = $unsigned(iExt * iExt);
        sqQ_d     = $unsigned(qExt * qExt);
        mag2_d    = sqI_q + sqQ_q;
        bestMag_d = bestMag_q;
        bestIdx_d = bestIdx_q;
        if (v2_q && ((idx2_q == '0) || (mag2_q > bestMag_q))) begin
            bestMag_d = mag2_q;
            bestIdx_d = idx2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            sqI_q     <= '0;
            sqQ_q     <= '0;
            idx1_q    <= '0;
            mag2_q    <= '0;
            idx2_q    <= '0;
            bestMag_q <= '0;
            bestIdx_q <= '0;
        end else begin
            v1_q <= accept;
            if (accept) begin
                sqI_q  <= sqI_d;
                sqQ_q  <= sqQ_d;
                idx1_q <= cnt_q;
            end
            v2_q <= v1_q;
            if (v1_q) begin
                mag2_q <= mag2_d;
                idx2_q <= idx1_q;
            end
            bestMag_q <= bestMag_d;
            bestIdx_q <= bestIdx_d;
        end
    end

    assign s_axis_product_tready = tready_q;
    assign s_axis_peak_tvalid    = tvalid_q;
    assign peak_index            = peakIdx_q;
    assign peak_mag              = peakMag_q;

endmodule

// File: doc/caf_peak_search.md
CAF_PEAK_SEARCH -- requirements
Module: caf_peak_search

Interface
REQ-001 SHALL have parameter i_bits, default 24, signed width of input in-phase sum.
REQ-002 SHALL have parameter q_bits, default 24, signed width of input quadrature sum; i_bits == q_bits.
REQ-003 SHALL have parameter frame_len, default 16, number of accepted samples per search frame, >= 2.
REQ-004 SHALL have parameter index_bits, default 4, width of peak index; 2**index_bits >= frame_len.
REQ-005 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports: m_axis_product_tvalid  in  1  upstream dot-product sample valid.
REQ-008 SHALL have ports: i  in  i_bits  signed in-phase sum; q  in  q_bits  signed quadrature sum.
REQ-009 SHALL have ports: s_axis_product_tready  out  1  ready to upstream dot-product stage.
REQ-010 SHALL have ports: s_axis_peak_tvalid  out  1  peak result valid.
REQ-011 SHALL have ports: m_axis_peak_tready  in  1  downstream accepts peak result.
REQ-012 SHALL have ports: peak_index  out  index_bits  frame position of peak; peak_mag  out  i_bits+q_bits  unsigned peak magnitude squared.

Function
REQ-013 SHALL accept a sample on a rising edge where m_axis_product_tvalid & s_axis_product_tready; all other samples ignored.
REQ-014 SHALL compute mag = i*i + q*q exactly, unsigned, i_bits+q_bits wide, with no truncation or wrap.
REQ-015 SHALL pipeline: edge k accept and register squares; edge k+1 register sum and sample index; edge k+2 compare/update running best.
REQ-016 SHALL tag accepted samples with index 0..frame_len-1 in acceptance order, resetting to 0 at each new frame.
REQ-017 SHALL load the running best unconditionally from index 0 of each frame; later samples replace it only if strictly greater (ties keep earliest index).
REQ-018 SHALL implement states IDLE, SEARCH, DRAIN, HOLD.
REQ-019 SHALL transition IDLE -> SEARCH on first edge after reset release, unconditionally.
REQ-020 SHALL transition SEARCH -> DRAIN on the edge accepting index frame_len-1.
REQ-021 SHALL remain in DRAIN exactly 3 edges, then enter HOLD, registering best mag/index into peak_mag/peak_index and setting s_axis_peak_tvalid.
REQ-022 SHALL produce s_axis_peak_tvalid = 1 after the 3rd edge following acceptance of the final sample.
REQ-023 SHALL drive s_axis_product_tready = 1 only in SEARCH, as registered output.
REQ-024 SHALL hold peak_index, peak_mag, s_axis_peak_tvalid stable in HOLD until an edge with m_axis_peak_tready = 1.
REQ-025 SHALL on that handshake edge clear s_axis_peak_tvalid, clear sample counter, return to SEARCH; tready high next cycle.
REQ-026 SHALL keep peak_index/peak_mag at last delivered values outside HOLD.
REQ-027 SHALL tolerate arbitrary gaps in m_axis_product_tvalid within a frame without affecting result.
REQ-028 SHALL ignore m_axis_peak_tready outside HOLD.

Reset
REQ-029 SHALL on rst_n low immediately force state IDLE, counters 0, running best 0, pipeline valids 0.
REQ-030 SHALL reset outputs: s_axis_product_tready 0, s_axis_peak_tvalid 0, peak_index 0, peak_mag 0.
REQ-031 SHALL discard any partial frame on reset; first frame after release starts at index 0.

Verification (frame_len = 4, i_bits = q_bits = 24)
REQ-032 SHALL cover: assert rst_n low mid-cycle -> all outputs 0 without clock edge; release -> tready 1 after first edge.
REQ-033 SHALL cover: samples (1,1),(3,-4),(-5,0),(2,2) back-to-back -> peak_index 1, peak_mag 25, tvalid 3 edges after 4th accept (tie keeps index 1).
REQ-034 SHALL cover: all samples i = q = -8388608 -> peak_mag 140737488355328, peak_index 0, no wrap.
REQ-035 SHALL cover: same frame as REQ-033 with tvalid toggling every other cycle -> identical result; tready 0 throughout DRAIN/HOLD.
REQ-036 SHALL cover: m_axis_peak_tready low 10 cycles in HOLD while upstream offers samples -> outputs stable, no samples accepted; then handshake -> next frame (0,7),(1,1),(0,0),(0,0) gives index 0, mag 49.
REQ-037 SHALL cover: rst_n pulsed after 2 accepted samples -> frame discarded; following 4-sample frame reports only its own peak.
